instr_decode_sb: RTL
====================

# instr_decode_sb

Parametrised decode stage with a valid/ready handshake, replacing the fixed stall-driven decoder. It decodes the 32-bit instruction word into ALU, memory and audio opcodes, operands and writeback control. An 8-entry register scoreboard stalls issue on RAW/WAW hazards against in-flight writers. It sits between the fetch buffer and the execute stage, reads the register file combinationally, and receives retire notifications from writeback.

## Interface
- DATA_W, 32: operand width, ≥32; bits above 31 of immediate-built operands are zero.
- NUM_CHANNELS, 4: implemented audio channels, 1..4; audio instructions with channel ≥ NUM_CHANNELS are illegal.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents in_instr.
- in_ready  out  1  decode accepts this cycle (combinational).
- in_instr  in  32  instruction word: [31] imm, [30:29] type, [28:26] op, [25:24] channel, [21:19] rs1/rd, [18:16] rs2, [15:0] imm16.
- rs1_sel, rs2_sel  out  3  = in_instr[21:19], in_instr[18:16].
- rs1_value, rs2_value  in  DATA_W  register file read data; register file is write-first.
- wb_valid  in  1  a writer retires this cycle.
- wb_reg  in  3  register retired.
- flush  in  1  discard the output-register entry.
- out_valid  out  1  output entry valid.
- out_ready  in  1  execute accepts the entry.
- out_alu_opcode  out  3;  out_mem_code  out  5;  out_audio_opcode  out  3.
- out_op1, out_op2  out  DATA_W  operands.
- out_wb_enable  out  2  01 low half, 10 high half, 11 full, 00 none.
- out_wb_reg  out  3  destination (= rs1 field).
- out_channel  out  2  audio channel.
- out_illegal  out  1  entry was an illegal instruction, converted to nop.
- out_instr  out  32  raw word for the VGA debug view; 0 for nop/illegal.

## Operation
- Classes by type: 00 nop; 01 with op 101/110/111 move (lower/upper/full), other op arithmetic; 10 memory; 11 audio.
- Opcodes:
  - arithmetic: alu = op;
  - memory: mem_code = {op[2], op[1], op[1], op[0], op[0]};
  - audio: audio = op;
  - all other opcode fields 0.
- Writeback enable:
  - move-lower or memory op 001 → 01;
  - move-upper or memory op 010 → 10;
  - other arithmetic or move → 11;
  - everything else → 00.
- Operands, imm=1:
  - arithmetic, memory, move-lower: op1 = rs1_value, op2 = zext(imm16).
  - move-upper: op2 = imm16 << 16.
  - audio op 100: op1 = imm16 << 16.
  - audio op 110: op1 = imm16 << 8.
  - unmatched: register operands.
- Operands, imm=0: op1 = rs1_value, op2 = rs2_value.
- Illegal: audio with channel ≥ NUM_CHANNELS.
  - Issued as nop: all opcodes 0, wb 00, out_instr 0.
  - out_illegal = 1; nothing marked busy.
- Scoreboard: busy[7:0].
  - busy_eff = busy & ~(wb_valid ? onehot(wb_reg) : 0).
  - Hazard = busy_eff[rs1] | (!imm & busy_eff[rs2]) | (wb_enable≠00 & busy_eff[rd]).
  - Nop/illegal never hazard.
- in_ready = reset_n & !flush & !hazard & (!out_valid | out_ready).
- Issue = in_valid & in_ready.
  - Output register loads; out_valid = 1.
  - busy[rd] is set if wb_enable≠00.
- out_valid clears when out_ready is high and no issue occurs.
- Retire: wb_valid clears busy[wb_reg].
  - Set and clear of the same register in one cycle: set wins.
  - Clear of a non-busy register: no effect.
- Flush:
  - out_valid → 0.
  - busy[out_wb_reg] clears if out_valid and out_wb_enable≠00.
  - No issue that cycle.

## Timing
- Latency: accepted instruction appears on outputs the next cycle; throughput 1/cycle.
- Output register holds all fields stable while out_valid & !out_ready.
- Hazard clears in the same cycle wb_valid retires the blocking register; issue is not delayed an extra cycle.
- Reset (asynchronous, reset_n low):
  - out_valid, out_illegal, all opcodes, operands, out_wb_enable, out_wb_reg, out_channel, out_instr → 0.
  - busy → 0; in_ready low while reset_n is low.
- Reset deasserted mid-stream: first issue is possible on the first edge with reset_n high.
- Flush with out_ready high in the same cycle: flush wins; entry is dropped, not accepted.

## Test plan
- Back-to-back independent: add r1,r2 then add r3,r4 with out_ready=1 → two consecutive out_valid cycles, alu_opcode = op, wb_enable = 11, no bubble.
- RAW stall: add r1,r2 issued (busy[1] = 1), then sub r5,r1 → in_ready=0 until wb_valid with wb_reg=1; issue occurs in that same cycle.
- Immediates with DATA_W=64:
  - move-upper imm16=0xBEEF → op2 = 0x00000000_BEEF0000, wb 10.
  - audio op 110 imm16=0x1234 → op1 = 0x123400.
- Illegal channel with NUM_CHANNELS=2: audio op 100, channel 3 → out_illegal=1, all opcodes 0, out_instr=0, busy unchanged.
- Backpressure and flush:
  - out_ready=0 for 3 cycles → outputs stable, in_ready=0.
  - flush with entry "mov r6" → out_valid=0, busy[6]=0.
- Async reset mid-stall: reset_n low with busy=0x0A and out_valid=1 → all outputs 0 and busy 0 immediately; first issue accepted on the first edge after release.

Source files
------------

// File: rtl/instr_decode_sb.sv
// instr_decode_sb: decode stage between the fetch buffer and execute.
// Splits a 32-bit instruction word into ALU / memory / audio opcodes,
// operands and writeback control, and holds issue back while an 8-entry
// register scoreboard reports a RAW/WAW hazard against an in-flight writer.
// Input side and output side both use a valid/ready handshake; the output
// side is a single register stage.

module instr_decode_sb #(
    parameter int DATA_W       = 32,
    parameter int NUM_CHANNELS = 4
) (
    input  logic              clock,
    input  logic              reset_n,

    // fetch side
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,

    // register file read port (combinational, write-first)
    output logic [2:0]        rs1_sel,
    output logic [2:0]        rs2_sel,
    input  logic [DATA_W-1:0] rs1_value,
    input  logic [DATA_W-1:0] rs2_value,

    // writeback retire notification
    input  logic              wb_valid,
    input  logic [2:0]        wb_reg,

    // pipeline control
    input  logic              flush,

    // execute side
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_alu_opcode,
    output logic [4:0]        out_mem_code,
    output logic [2:0]        out_audio_opcode,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [1:0]        out_wb_enable,
    output logic [2:0]        out_wb_reg,
    output logic [1:0]        out_channel,
    output logic              out_illegal,
    output logic [31:0]       out_instr
);

    // ------------------------------------------------------------------
    // Types
    // ------------------------------------------------------------------

    // Instruction class after legality screening; illegal words fold to NOP.
    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ARITH,
        CLS_MOVE_LO,
        CLS_MOVE_HI,
        CLS_MOVE_FULL,
        CLS_MEM,
        CLS_AUDIO
    } instr_class_e;

    // Which half of the destination register a writer updates.
    typedef enum logic [1:0] {
        WB_NONE = 2'b00,
        WB_LOW  = 2'b01,
        WB_HIGH = 2'b10,
        WB_FULL = 2'b11
    } wb_enable_e;

    // Contents of the output register.
    typedef struct packed {
        logic [2:0]        alu_opcode;
        logic [4:0]        mem_code;
        logic [2:0]        audio_opcode;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        wb_enable_e        wb_enable;
        logic [2:0]        wb_reg;
        logic [1:0]        channel;
        logic              illegal;
        logic [31:0]       instr;
    } entry_t;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic        f_imm;
    logic [1:0]  f_type;
    logic [2:0]  f_op;
    logic [1:0]  f_channel;
    logic [2:0]  f_rs1;
    logic [2:0]  f_rs2;
    logic [15:0] f_imm16;
    logic        chan_illegal;

    assign f_imm     = in_instr[31];
    assign f_type    = in_instr[30:29];
    assign f_op      = in_instr[28:26];
    assign f_channel = in_instr[25:24];
    assign f_rs1     = in_instr[21:19];
    assign f_rs2     = in_instr[18:16];
    assign f_imm16   = in_instr[15:0];

    assign rs1_sel = f_rs1;
    assign rs2_sel = f_rs2;

    // Channels at or above the implemented count do not exist in hardware.
    assign chan_illegal = (int'(f_channel) >= NUM_CHANNELS);

    // Immediate shapes, built at 32 bits so anything above bit 31 is zero.
    logic [31:0] imm_zext;
    logic [31:0] imm_shl8;
    logic [31:0] imm_shl16;

    assign imm_zext  = {16'd0, f_imm16};
    assign imm_shl8  = {8'd0, f_imm16, 8'd0};
    assign imm_shl16 = {f_imm16, 16'd0};

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    instr_class_e dec_class;
    logic         dec_illegal;
    logic [2:0]   dec_alu;
    logic [4:0]   dec_mem;
    logic [2:0]   dec_audio;
    logic [1:0]   dec_channel;
    wb_enable_e   dec_wb;
    logic [31:0]  dec_instr;
    logic [DATA_W-1:0] dec_op1;
    logic [DATA_W-1:0] dec_op2;
    entry_t       dec_entry;

    // Classify the word; audio on an unimplemented channel becomes a flagged nop.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        dec_class   = CLS_NOP;
        dec_illegal = 1'b0;
        case (f_type)
            2'b01: begin
                case (f_op)
                    3'b101:  dec_class = CLS_MOVE_LO;
                    3'b110:  dec_class = CLS_MOVE_HI;
                    3'b111:  dec_class = CLS_MOVE_FULL;
                    default: dec_class = CLS_ARITH;
                endcase
            end
            2'b10: dec_class = CLS_MEM;
            2'b11: begin
                if (chan_illegal) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_class = CLS_AUDIO;
                end
            end
            default: dec_class = CLS_NOP;
        endcase
    end

    // Opcode fields and writeback enable for each class; unused fields stay 0.
    always_comb begin
        dec_alu     = 3'd0;
        dec_mem     = 5'd0;
        dec_audio   = 3'd0;
        dec_channel = 2'd0;
        dec_wb      = WB_NONE;
        case (dec_class)
            CLS_ARITH: begin
                dec_alu = f_op;
                dec_wb  = WB_FULL;
            end
            CLS_MOVE_LO:   dec_wb = WB_LOW;
            CLS_MOVE_HI:   dec_wb = WB_HIGH;
            CLS_MOVE_FULL: dec_wb = WB_FULL;
            CLS_MEM: begin
                dec_mem = {f_op[2], f_op[1], f_op[1], f_op[0], f_op[0]};
                case (f_op)
                    3'b001:  dec_wb = WB_LOW;
                    3'b010:  dec_wb = WB_HIGH;
                    default: dec_wb = WB_NONE;
                endcase
            end
            CLS_AUDIO: begin
                dec_audio   = f_op;
                dec_channel = f_channel;
            end
            default: ;
        endcase
    end

    // The debug view only shows words that actually do something.
    assign dec_instr = (dec_class == CLS_NOP) ? 32'd0 : in_instr;

    // Operand selection: register values unless an immediate form overrides one.
    always_comb begin
        dec_op1 = rs1_value;
        dec_op2 = rs2_value;
        if (f_imm) begin
            case (dec_class)
                CLS_ARITH, CLS_MEM, CLS_MOVE_LO: dec_op2 = DATA_W'(imm_zext);
                CLS_MOVE_HI:                     dec_op2 = DATA_W'(imm_shl16);
                CLS_AUDIO: begin
                    if (f_op == 3'b100) begin
                        dec_op1 = DATA_W'(imm_shl16);
                    end else if (f_op == 3'b110) begin
                        dec_op1 = DATA_W'(imm_shl8);
                    end
                end
                default: ;
            endcase
        end
    end

    // Pack the decoded fields into the shape of the output register.
    always_comb begin
        dec_entry              = '0;
        dec_entry.alu_opcode   = dec_alu;
        dec_entry.mem_code     = dec_mem;
        dec_entry.audio_opcode = dec_audio;
        dec_entry.op1          = dec_op1;
        dec_entry.op2          = dec_op2;
        dec_entry.wb_enable    = dec_wb;
        dec_entry.wb_reg       = f_rs1;
        dec_entry.channel      = dec_channel;
        dec_entry.illegal      = dec_illegal;
        dec_entry.instr        = dec_instr;
    end

    // ------------------------------------------------------------------
    // Scoreboard and handshake
    // ------------------------------------------------------------------
    logic [7:0] busy_q, busy_d;
    logic [7:0] retire_mask;
    logic [7:0] busy_eff;
    logic       hazard;
    logic       issue;
    logic       out_valid_q, out_valid_d;
    entry_t     entry_q, entry_d;

    // A register retiring this cycle no longer blocks, so issue is not delayed.
    assign retire_mask = wb_valid ? (8'd1 << wb_reg) : 8'd0;
    assign busy_eff    = busy_q & ~retire_mask;

    assign hazard = (dec_class != CLS_NOP) &&
                    (busy_eff[f_rs1] ||
                     (!f_imm && busy_eff[f_rs2]) ||
                     ((dec_wb != WB_NONE) && busy_eff[f_rs1]));

    assign in_ready = reset_n && !flush && !hazard && (!out_valid_q || out_ready);
    assign issue    = in_valid && in_ready;

    // Scoreboard update: retire and flush clear, issue sets (set wins on a tie).
    always_comb begin
        busy_d = busy_q & ~retire_mask;
        if (flush && out_valid_q && (entry_q.wb_enable != WB_NONE)) begin
            busy_d[entry_q.wb_reg] = 1'b0;
        end
        if (issue && (dec_wb != WB_NONE)) begin
            busy_d[f_rs1] = 1'b1;
        end
    end

    // Output register: load on issue, drop on flush or when execute drains it.
    always_comb begin
        entry_d     = entry_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (issue) begin
            entry_d     = dec_entry;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset clears every output field and the scoreboard.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the scoreboard is a small flop vector, not a RAM, so it is
            // reset along with the control state; stale busy bits would stall forever.
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            entry_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge value of every other flop, independent of statement order.
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            entry_q     <= entry_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid        = out_valid_q;
    assign out_alu_opcode   = entry_q.alu_opcode;
    assign out_mem_code     = entry_q.mem_code;
    assign out_audio_opcode = entry_q.audio_opcode;
    assign out_op1          = entry_q.op1;
    assign out_op2          = entry_q.op2;
    assign out_wb_enable    = entry_q.wb_enable;
    assign out_wb_reg       = entry_q.wb_reg;
    assign out_channel      = entry_q.channel;
    assign out_illegal      = entry_q.illegal;
    assign out_instr        = entry_q.instr;

endmodule
